rom_read_arbiter: RTL and testbench

ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

---
 rtl/rom_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-requester ROM read arbiter: burst-limited round-robin grants with a
// LATENCY-deep tag pipeline that routes returning ROM data to its requester.
module rom_read_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_dout,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic               gnt0, gnt1;
  logic               rvalid;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= MAX_B) ? MAX_B : v + 8'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    burst_cnt_d = burst_cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    if (i_flush) begin
      state_d     = IDLE;
      burst_cnt_d = 8'd0;
      rr_d        = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // On contention the requester that did not own last time wins.
          if (i_req0 && (!i_req1 || rr_q)) begin
            gnt0        = 1'b1;
            state_d     = OWN0;
            burst_cnt_d = 8'd1;
          end else if (i_req1) begin
            gnt1        = 1'b1;
            state_d     = OWN1;
            burst_cnt_d = 8'd1;
          end
        end
        OWN0: begin
          if (i_req0 && (burst_cnt_q < MAX_B || !i_req1)) begin
            gnt0        = 1'b1;
            burst_cnt_d = sat_inc(burst_cnt_q);
          end else begin
            rr_d = 1'b0;
            if (i_req1) begin
              gnt1        = 1'b1;
              state_d     = OWN1;
              burst_cnt_d = 8'd1;
            end else begin
              state_d     = IDLE;
              burst_cnt_d = 8'd0;
            end
          end
        end
        OWN1: begin
          if (i_req1 && (burst_cnt_q < MAX_B || !i_req0)) begin
            gnt1        = 1'b1;
            burst_cnt_d = sat_inc(burst_cnt_q);
          end else begin
            rr_d = 1'b1;
            if (i_req0) begin
              gnt0        = 1'b1;
              state_d     = OWN0;
              burst_cnt_d = 8'd1;
            end else begin
              state_d     = IDLE;
              burst_cnt_d = 8'd0;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
        end
      endcase
    end
  end

  assign o_gnt0     = gnt0 & ~rst;
  assign o_gnt1     = gnt1 & ~rst;
  assign o_rom_ce   = o_gnt0 | o_gnt1;
  assign o_rom_addr = o_gnt1 ? i_addr1 : i_addr0;

  // Tag pipeline: one slot per cycle of ROM latency, slot 0 is the newest read.
  always_comb begin
    tag_vld_d = '0;
    tag_id_d  = '0;
    if (!i_flush) begin
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_id_d[i]  = tag_id_q[i-1];
      end
      tag_vld_d[0] = o_gnt0 | o_gnt1;
      tag_id_d[0]  = o_gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      burst_cnt_q <= 8'd0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  // Data arriving in a flush cycle belongs to a discarded read.
  assign rvalid    = tag_vld_q[LATENCY-1] & ~i_flush & ~rst;
  assign o_rvalid0 = rvalid & ~tag_id_q[LATENCY-1];
  assign o_rvalid1 = rvalid & tag_id_q[LATENCY-1];
  assign o_rdata   = i_rom_dout;
  assign o_busy    = (|tag_vld_q) & ~rst;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus randomized traffic,
// with a per-cycle monitor against a transaction-level arbitration model.
module tb_rom_read_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LAT    = 2;
  localparam int MAXB   = 16;

  logic              clk = 1'b0;
  logic              rst, i_flush, i_req0, i_req1;
  logic [ADDR_W-1:0] i_addr0, i_addr1;
  logic              o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rom_ce, o_busy;
  logic [DATA_W-1:0] o_rdata, i_rom_dout;
  logic [ADDR_W-1:0] o_rom_addr;

  always #5 clk = ~clk;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_req0(i_req0), .i_req1(i_req1), .i_addr0(i_addr0), .i_addr1(i_addr1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata(o_rdata), .o_rom_ce(o_rom_ce), .o_rom_addr(o_rom_addr),
    .i_rom_dout(i_rom_dout), .o_busy(o_busy)
  );

  // ROM: dout = low byte of the address presented LAT cycles earlier.
  logic [7:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= o_rom_addr[7:0];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign i_rom_dout = rom_pipe[LAT-1];

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rd_t;

  rd_t pend[$];
  int  owner = -1, run = 0, last = 1, cyc = 0;
  int  checks = 0, errors = 0;
  int  gnt_cnt = 0, rv_cnt = 0, dropped = 0;

  // Who should be granted this cycle, from the ownership/burst rules.
  function automatic int pick(input logic r0, input logic r1);
    logic ro, rt;
    if (owner >= 0) begin
      ro = (owner == 0) ? r0 : r1;
      rt = (owner == 0) ? r1 : r0;
      if (ro && (run < MAXB || !rt)) return owner;
      if (rt) return 1 - owner;
      return -1;
    end
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int         eg, erv;
    logic [7:0] ed, ga;
    logic       busy_e;
    logic [ADDR_W-1:0] ea;
    cyc++;
    eg     = (rst || i_flush) ? -1 : pick(i_req0, i_req1);
    busy_e = !rst && (pend.size() > 0);
    erv    = -1;
    ed     = '0;
    if (!rst && !i_flush && pend.size() > 0 && pend[0].due == cyc) begin
      erv = pend[0].id;
      ed  = pend[0].data;
      void'(pend.pop_front());
    end
    checks++;
    if ({o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy} !==
        {eg == 0, eg == 1, eg >= 0, erv == 0, erv == 1, busy_e}) begin
      errors++;
      $display("FAIL mon_ctrl cyc %0d gnt0/gnt1/ce/rv0/rv1/busy got %b%b%b%b%b%b exp %b%b%b%b%b%b",
               cyc, o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy,
               eg == 0, eg == 1, eg >= 0, erv == 0, erv == 1, busy_e);
    end
    checks++;
    if (o_gnt0 && o_gnt1) begin
      errors++;
      $display("FAIL mon_mutex cyc %0d both grants high", cyc);
    end
    ea = (eg == 1) ? i_addr1 : i_addr0;
    checks++;
    if (o_rom_addr !== ea) begin
      errors++;
      $display("FAIL mon_addr cyc %0d got %h exp %h", cyc, o_rom_addr, ea);
    end
    if (erv >= 0) begin
      checks++;
      if (o_rdata !== ed) begin
        errors++;
        $display("FAIL mon_rdata cyc %0d got %h exp %h", cyc, o_rdata, ed);
      end
    end
    gnt_cnt += int'(o_gnt0 | o_gnt1);
    rv_cnt  += int'(o_rvalid0 | o_rvalid1);
    if (rst || i_flush) begin
      dropped += pend.size();
      pend.delete();
      owner = -1;
      run   = 0;
      last  = 1;
    end else if (eg >= 0) begin
      ga = ea[7:0];
      pend.push_back('{cyc + LAT, eg, ga});
      if (owner >= 0 && eg != owner) last = owner;
      run   = (eg == owner) ? ((run < MAXB) ? run + 1 : MAXB) : 1;
      owner = eg;
    end else begin
      if (owner >= 0) last = owner;
      owner = -1;
      run   = 0;
    end
  end

  task automatic drive(input logic r0, input logic r1, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] a1, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    i_req0 = r0; i_req1 = r1; i_addr0 = a0; i_addr1 = a1; i_flush = fl; rst = rs;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 16'h1234 + 16'(k), 16'h5678, 1'b0, 1'b1);
      #1;
      checks++;
      if ({o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b%b%b%b%b%b exp 000000",
                 o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy);
      end
      checks++;
      if (o_rom_addr !== 16'h1234 + 16'(k)) begin
        errors++;
        $display("FAIL reset_addr got %h exp %h", o_rom_addr, 16'h1234 + 16'(k));
      end
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy} !== 6'b0) begin
      errors++;
      $display("FAIL after_reset got %b%b%b%b%b%b exp 000000",
               o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy);
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 9; k++) begin
      if (k < 5) drive(1'b1, 1'b0, 16'(10 + k), 16'h0, 1'b0, 1'b0);
      else       drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if (o_gnt0 !== (k < 5) || o_gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL single_gnt k %0d got %b%b exp %b0", k, o_gnt0, o_gnt1, k < 5);
      end
      checks++;
      if (o_rvalid0 !== (k >= 2 && k < 7)) begin
        errors++;
        $display("FAIL single_rvalid k %0d got %b exp %b", k, o_rvalid0, k >= 2 && k < 7);
      end
      if (k >= 2 && k < 7) begin
        checks++;
        if (o_rdata !== 8'(10 + k - 2)) begin
          errors++;
          $display("FAIL single_rdata k %0d got %0d exp %0d", k, o_rdata, 10 + k - 2);
        end
      end
    end
  endtask

  task automatic test_contention();
    int exp_id;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 44; k++) begin
      if (k < 40) drive(1'b1, 1'b1, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 1'b0, 1'b0);
      else        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      exp_id = (k < 16) ? 0 : (k < 32) ? 1 : 0;
      #1;
      if (k < 40) begin
        checks++;
        if ({o_gnt0, o_gnt1, o_rom_ce} !== {exp_id == 0, exp_id == 1, 1'b1}) begin
          errors++;
          $display("FAIL contention_gnt k %0d gnt0/gnt1/ce got %b%b%b exp %b%b1",
                   k, o_gnt0, o_gnt1, o_rom_ce, exp_id == 0, exp_id == 1);
        end
      end
      if (k >= LAT && k < 40 + LAT) begin
        exp_id = ((k - LAT) < 16) ? 0 : ((k - LAT) < 32) ? 1 : 0;
        checks++;
        if ({o_rvalid0, o_rvalid1} !== {exp_id == 0, exp_id == 1}) begin
          errors++;
          $display("FAIL contention_rvalid k %0d got %b%b exp %b%b",
                   k, o_rvalid0, o_rvalid1, exp_id == 0, exp_id == 1);
        end
      end
    end
  endtask

  task automatic test_yield();
    for (int k = 0; k < 5; k++) begin
      if (k < 3)       drive(1'b1, 1'b0, 16'h0030 + 16'(k), 16'h0040, 1'b0, 1'b0);
      else if (k == 3) drive(1'b0, 1'b1, 16'h0033, 16'h0043, 1'b0, 1'b0);
      else             drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (k < 4) begin
        checks++;
        if ({o_gnt0, o_gnt1, o_rom_ce} !== {k < 3, k == 3, 1'b1}) begin
          errors++;
          $display("FAIL yield k %0d gnt0/gnt1/ce got %b%b%b exp %b%b1",
                   k, o_gnt0, o_gnt1, o_rom_ce, k < 3, k == 3);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 7; k++) begin
      if (k < 2)       drive(1'b0, 1'b1, 16'h0, 16'h0070 + 16'(k), 1'b0, 1'b0);
      else if (k == 2) drive(1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0);
      else if (k == 3) drive(1'b1, 1'b1, 16'h0080, 16'h0090, 1'b0, 1'b0);
      else             drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (k >= 2) begin
        checks++;
        if (o_rvalid1 !== 1'b0) begin
          errors++;
          $display("FAIL flush_rvalid1 k %0d got %b exp 0", k, o_rvalid1);
        end
      end
      if (k == 2) begin
        checks++;
        if ({o_gnt0, o_gnt1} !== 2'b00) begin
          errors++;
          $display("FAIL flush_gnt got %b%b exp 00", o_gnt0, o_gnt1);
        end
      end
      if (k == 3) begin
        checks++;
        if ({o_busy, o_gnt0, o_gnt1} !== 3'b010) begin
          errors++;
          $display("FAIL flush_after busy/gnt0/gnt1 got %b%b%b exp 010", o_busy, o_gnt0, o_gnt1);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 6)       drive(1'b0, 1'b1, 16'h00AA, 16'h00B0 + 16'(k), 1'b0, 1'b0);
      else if (k == 6) drive(1'b0, 1'b1, 16'h00AA, 16'h00C0, 1'b0, 1'b1);
      else             drive(1'b0, 1'b0, 16'h00AB, 16'h0, 1'b0, 1'b0);
      #1;
      if (k >= 6) begin
        checks++;
        if ({o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy} !== 6'b0) begin
          errors++;
          $display("FAIL mid_reset k %0d got %b%b%b%b%b%b exp 000000",
                   k, o_gnt0, o_gnt1, o_rom_ce, o_rvalid0, o_rvalid1, o_busy);
        end
      end
    end
  endtask

  task automatic test_random();
    int   mode;
    logic r0, r1, fl, rs;
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) mode = $urandom_range(0, 3);
      case (mode)
        0: begin r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0); end
        1: begin r0 = 1'b1; r1 = 1'b1; end
        2: begin r0 = 1'b1; r1 = ($urandom_range(0, 7) == 0); end
        default: begin r0 = ($urandom_range(0, 1) != 0); r1 = 1'b1; end
      endcase
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 199) == 0);
      drive(r0, r1, 16'($urandom), 16'($urandom), fl, rs);
    end
    idle(LAT + 4);
    checks++;
    if (rv_cnt !== gnt_cnt - dropped) begin
      errors++;
      $display("FAIL conservation rvalids %0d exp grants %0d - dropped %0d", rv_cnt, gnt_cnt, dropped);
    end
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
    i_addr0 = '0; i_addr1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_yield();
    test_flush();
    idle(3);
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
